// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shared-bus front end that arbitrates the cpu fetch and data ports onto
// one single-ported synchronous RAM plus PERIPH_CNT memory-mapped peripheral windows.
// It provides alternating priority, address decode, peripheral wait-states with timeout,
// and bus error reporting.
// Optional feature: define BUS_STATS_EN to add the conflictCnt/errCnt statistics outputs.
module mem_bus_arbiter #(
  parameter int unsigned       DATA_W           = 32,
  parameter int unsigned       ADDR_W           = 32,
  parameter int unsigned       PERIPH_CNT       = 2,
  parameter logic [ADDR_W-1:0] PERIPH_BASE      = 32'hFFFF_0000,
  parameter int unsigned       PERIPH_SPAN_LOG2 = 8,
  parameter int unsigned       TIMEOUT          = 15
) (
  input  logic                           sysClk,
  input  logic                           sysRes,
  input  logic                           iReq,
  input  logic [ADDR_W-1:0]              iAddr,
  output logic [DATA_W-1:0]              iRdata,
  output logic                           iAck,
  output logic                           iErr,
  input  logic                           dReq,
  input  logic                           dWe,
  input  logic [DATA_W/8-1:0]            dMask,
  input  logic [ADDR_W-1:0]              dAddr,
  input  logic [DATA_W-1:0]              dWdata,
  output logic [DATA_W-1:0]              dRdata,
  output logic                           dAck,
  output logic                           dErr,
  output logic                           mEn,
  output logic                           mWe,
  output logic [DATA_W/8-1:0]            mMask,
  output logic [ADDR_W-1:0]              mAddr,
  output logic [DATA_W-1:0]              mWdata,
  input  logic [DATA_W-1:0]              mRdata,
  output logic [PERIPH_CNT-1:0]          pSel,
  output logic                           pWe,
  output logic [DATA_W/8-1:0]            pMask,
  output logic [PERIPH_SPAN_LOG2-1:0]    pAddr,
  output logic [DATA_W-1:0]              pWdata,
  input  logic [PERIPH_CNT*DATA_W-1:0]   pRdata,
  input  logic [PERIPH_CNT-1:0]          pReady
`ifdef BUS_STATS_EN
  ,
  output logic [15:0]                    conflictCnt,
  output logic [15:0]                    errCnt
`endif
);

  localparam int unsigned MaskW = DATA_W / 8;
  localparam int unsigned IdxW  = (PERIPH_CNT > 1) ? $clog2(PERIPH_CNT) : 1;

  typedef enum logic [2:0] {StIdle, StMemIssue, StMemWait, StPeriph, StErr} state_e;

  state_e              state_q, state_d;
  logic                gnt_data_q, gnt_data_d;  // side of current/last grant, 1 = data
  logic                we_q, we_d;
  logic [MaskW-1:0]    mask_q, mask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [7:0]          cnt_q, cnt_d;

  logic                  sel_data;
  logic [ADDR_W-1:0]     req_addr, idx_full;
  logic                  is_ram, is_periph;
  logic                  p_ready_sel, timeout;
  logic [DATA_W-1:0]     p_rdata_sel;
  logic [PERIPH_CNT-1:0] p_onehot;
  logic                  ack, err;
  logic [DATA_W-1:0]     rdata;

  // Arbitration and address decode of the request seen in IDLE.
  always_comb begin
    if (iReq && dReq) sel_data = ~gnt_data_q;
    else              sel_data = dReq;
    req_addr  = sel_data ? dAddr : iAddr;
    is_ram    = (req_addr < PERIPH_BASE);
    // Only meaningful when !is_ram, so the subtraction never wraps.
    idx_full  = (req_addr - PERIPH_BASE) >> PERIPH_SPAN_LOG2;
    is_periph = !is_ram && (idx_full < ADDR_W'(PERIPH_CNT));
  end

  // Selected peripheral channel: one-hot select, ready and read data slice.
  always_comb begin
    p_onehot    = '0;
    p_ready_sel = 1'b0;
    p_rdata_sel = '0;
    for (int k = 0; k < int'(PERIPH_CNT); k++) begin
      if (idx_q == IdxW'(k)) begin
        p_onehot[k] = 1'b1;
        p_ready_sel = pReady[k];
        p_rdata_sel = pRdata[k*DATA_W +: DATA_W];
      end
    end
  end

  assign timeout = (cnt_q >= 8'(TIMEOUT));

  // Next-state logic and bus-side outputs.
  always_comb begin
    state_d    = state_q;
    gnt_data_d = gnt_data_q;
    we_d       = we_q;
    mask_d     = mask_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ack        = 1'b0;
    err        = 1'b0;
    rdata      = '0;
    mEn        = 1'b0;
    mWe        = 1'b0;
    mMask      = '0;
    mAddr      = '0;
    mWdata     = '0;
    pSel       = '0;
    pWe        = 1'b0;
    pMask      = '0;
    pAddr      = '0;
    pWdata     = '0;
    unique case (state_q)
      StIdle: begin
        if (iReq || dReq) begin
          gnt_data_d = sel_data;
          addr_d     = req_addr;
          we_d       = sel_data & dWe;
          mask_d     = sel_data ? dMask : '0;
          wdata_d    = sel_data ? dWdata : '0;
          idx_d      = idx_full[IdxW-1:0];
          cnt_d      = '0;
          if (is_ram)                     state_d = StMemIssue;
          else if (sel_data && is_periph) state_d = StPeriph;
          else                            state_d = StErr;
        end
      end
      StMemIssue: begin
        mEn     = 1'b1;
        mWe     = we_q;
        mMask   = mask_q;
        mAddr   = addr_q;
        mWdata  = wdata_q;
        state_d = StMemWait;
      end
      StMemWait: begin
        ack     = 1'b1;
        rdata   = we_q ? '0 : mRdata;
        state_d = StIdle;
      end
      StPeriph: begin
        pSel   = p_onehot;
        pWe    = we_q;
        pMask  = mask_q;
        pAddr  = addr_q[PERIPH_SPAN_LOG2-1:0];
        pWdata = wdata_q;
        // A ready arriving on the timeout cycle still wins.
        if (p_ready_sel) begin
          ack     = 1'b1;
          rdata   = p_rdata_sel;
          state_d = StIdle;
        end else if (timeout) begin
          ack     = 1'b1;
          err     = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StErr: begin
        ack     = 1'b1;
        err     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign iAck   = ack & ~gnt_data_q;
  assign iErr   = err & ~gnt_data_q;
  assign iRdata = gnt_data_q ? '0 : rdata;
  assign dAck   = ack & gnt_data_q;
  assign dErr   = err & gnt_data_q;
  assign dRdata = gnt_data_q ? rdata : '0;

  // State and latched-transaction registers.
  always_ff @(posedge sysClk or negedge sysRes) begin
    if (!sysRes) begin
      state_q    <= StIdle;
      gnt_data_q <= 1'b1;
      we_q       <= 1'b0;
      mask_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
      we_q       <= we_d;
      mask_q     <= mask_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef BUS_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating statistics: IDLE cycles with both requests pending, and error acks.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    err_cnt_d      = err_cnt_q;
    if (state_q == StIdle && iReq && dReq && conflict_cnt_q != 16'hFFFF) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
    if (ack && err && err_cnt_q != 16'hFFFF) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge sysClk or negedge sysRes) begin
    if (!sysRes) begin
      conflict_cnt_q <= '0;
      err_cnt_q      <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign conflictCnt = conflict_cnt_q;
  assign errCnt      = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scoreboard of expected acks checked by a monitor,
// plus per-scenario inline checks of strobes and decode.
module tb_mem_bus_arbiter;
  localparam int TO = 15;

  logic        sysClk = 1'b0;
  logic        sysRes = 1'b0;
  logic        iReq = 1'b0;
  logic [31:0] iAddr = '0;
  logic [31:0] iRdata;
  logic        iAck, iErr;
  logic        dReq = 1'b0, dWe = 1'b0;
  logic [3:0]  dMask = '0;
  logic [31:0] dAddr = '0, dWdata = '0;
  logic [31:0] dRdata;
  logic        dAck, dErr;
  logic        mEn, mWe;
  logic [3:0]  mMask;
  logic [31:0] mAddr, mWdata;
  logic [31:0] mRdata = '0;
  logic [1:0]  pSel;
  logic        pWe;
  logic [3:0]  pMask;
  logic [7:0]  pAddr;
  logic [31:0] pWdata;
  logic [63:0] pRdata = '0;
  logic [1:0]  pReady = '0;
`ifdef BUS_STATS_EN
  logic [15:0] conflictCnt, errCnt;
`endif

  typedef struct {
    bit          side;   // 1 = data
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  mem_bus_arbiter dut (
    .sysClk(sysClk), .sysRes(sysRes),
    .iReq(iReq), .iAddr(iAddr), .iRdata(iRdata), .iAck(iAck), .iErr(iErr),
    .dReq(dReq), .dWe(dWe), .dMask(dMask), .dAddr(dAddr), .dWdata(dWdata),
    .dRdata(dRdata), .dAck(dAck), .dErr(dErr),
    .mEn(mEn), .mWe(mWe), .mMask(mMask), .mAddr(mAddr), .mWdata(mWdata), .mRdata(mRdata),
    .pSel(pSel), .pWe(pWe), .pMask(pMask), .pAddr(pAddr), .pWdata(pWdata),
    .pRdata(pRdata), .pReady(pReady)
`ifdef BUS_STATS_EN
    , .conflictCnt(conflictCnt), .errCnt(errCnt)
`endif
  );

  always #5 sysClk = ~sysClk;
  always @(posedge sysClk) cyc <= cyc + 1;

  // Synchronous RAM model; unwritten words hold a known pattern.
  logic [31:0] ram [256];
  bit          ram_wr [256];

  function automatic logic [31:0] init_word(int k);
    return (k == 4) ? 32'hDEADBEEF : (32'hC0DE_0000 + 32'(k));
  endfunction

  always @(posedge sysClk) begin
    if (mEn) begin
      logic [31:0] cur;
      cur = ram_wr[mAddr[9:2]] ? ram[mAddr[9:2]] : init_word(int'(mAddr[9:2]));
      if (mWe) begin
        for (int b = 0; b < 4; b++) if (mMask[b]) cur[8*b +: 8] = mWdata[8*b +: 8];
        ram[mAddr[9:2]]    <= cur;
        ram_wr[mAddr[9:2]] <= 1'b1;
      end else begin
        mRdata <= cur;
      end
    end
  end

  // Pops one expected entry per ack and compares side, err, rdata and cycle.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge sysClk);
      if (iAck || dAck) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ack cyc=%0d iAck=%b dAck=%b required none", cyc, iAck, dAck);
        end else begin
          e = sb.pop_front();
          if ((iAck && dAck) || dAck !== e.side ||
              (dAck ? dErr : iErr) !== e.err ||
              (dAck ? dRdata : iRdata) !== e.rdata || cyc !== e.cyc) begin
            n_fail++;
            $display("FAIL ack cyc=%0d side=%b err=%b rdata=%h ; required cyc=%0d side=%b err=%b rdata=%h",
                     cyc, dAck, dAck ? dErr : iErr, dAck ? dRdata : iRdata,
                     e.cyc, e.side, e.err, e.rdata);
          end
        end
      end
    end
  endtask

  // Waits (bounded) until every expected ack has been seen; returns at posedge+1.
  task automatic wait_drain(output bit ok);
    int n = 0;
    while (sb.size() != 0 && n < 64) begin
      @(posedge sysClk);
      n++;
    end
    ok = (sb.size() == 0);
    sb.delete();
    #1;
  endtask

  task automatic apply_reset();
    sysRes = 1'b0;
    iReq = 1'b0; dReq = 1'b0; dWe = 1'b0; pReady = '0;
    repeat (2) @(posedge sysClk);
    #1 sysRes = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if ({iAck, iErr, dAck, dErr, mEn, mWe, pSel, pWe} !== '0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b required=0", {iAck, iErr, dAck, dErr, mEn, mWe, pSel, pWe});
    end
    apply_reset();
    @(negedge sysClk);
    n_tests++;
    if ({iRdata, dRdata, mAddr, mWdata, mMask, pMask, pAddr, pWdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_data got nonzero bus iRdata=%h dRdata=%h mAddr=%h required 0",
               iRdata, dRdata, mAddr);
    end
  endtask

  task automatic test_fetch();
    int c0; bit ok;
    @(posedge sysClk); #1; c0 = cyc;
    iReq = 1'b1; iAddr = 32'h10;
    sb.push_back('{1'b0, 1'b0, 32'hDEADBEEF, c0 + 2});
    @(negedge sysClk);
    @(negedge sysClk);
    n_tests++;
    if (mEn !== 1'b1 || mWe !== 1'b0 || mAddr !== 32'h10) begin
      n_fail++;
      $display("FAIL fetch_issue mEn=%b mWe=%b mAddr=%h required 1 0 00000010", mEn, mWe, mAddr);
    end
    wait_drain(ok);
    iReq = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL fetch_drain acks_seen=0 required=1"); end
  endtask

  task automatic test_conflict();
    int c0; bit ok;
    apply_reset();
    @(posedge sysClk); #1; c0 = cyc;
    iReq = 1'b1; iAddr = 32'h20;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h40;
    sb.push_back('{1'b0, 1'b0, init_word(8),  c0 + 2});
    sb.push_back('{1'b1, 1'b0, init_word(16), c0 + 5});
    sb.push_back('{1'b0, 1'b0, init_word(8),  c0 + 8});
    sb.push_back('{1'b1, 1'b0, init_word(16), c0 + 11});
    wait_drain(ok);
    iReq = 1'b0; dReq = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL conflict_drain acks_missing required=4"); end
`ifdef BUS_STATS_EN
    @(negedge sysClk);
    n_tests++;
    if (conflictCnt !== 16'd4) begin
      n_fail++; $display("FAIL conflict_cnt got=%0d required=4", conflictCnt);
    end
`endif
  endtask

  task automatic test_ram_write();
    int c0; bit ok;
    @(posedge sysClk); #1; c0 = cyc;
    dReq = 1'b1; dWe = 1'b1; dMask = 4'b0101; dAddr = 32'h40; dWdata = 32'h11223344;
    sb.push_back('{1'b1, 1'b0, 32'h0, c0 + 2});
    @(negedge sysClk);
    @(negedge sysClk);
    n_tests++;
    if (mEn !== 1'b1 || mWe !== 1'b1 || mMask !== 4'b0101 || mWdata !== 32'h11223344) begin
      n_fail++;
      $display("FAIL ram_write_issue mEn=%b mWe=%b mMask=%b mWdata=%h required 1 1 0101 11223344",
               mEn, mWe, mMask, mWdata);
    end
    wait_drain(ok);
    dReq = 1'b0; dWe = 1'b0;
    @(posedge sysClk); #1; c0 = cyc;
    dReq = 1'b1;
    sb.push_back('{1'b1, 1'b0,
                   (init_word(16) & 32'hFF00FF00) | (32'h11223344 & 32'h00FF00FF), c0 + 2});
    wait_drain(ok);
    dReq = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL ram_readback_drain ack_missing required=1"); end
  endtask

  task automatic test_periph();
    int c0; bit ok;
    pRdata = {32'h1111_2222, 32'h3333_4444};
    pReady = 2'b01;  // unselected channel ready must be ignored
    @(posedge sysClk); #1; c0 = cyc;
    dReq = 1'b1; dWe = 1'b1; dMask = 4'b0011; dAddr = 32'hFFFF_0104; dWdata = 32'hCAFE_F00D;
    sb.push_back('{1'b1, 1'b0, 32'h1111_2222, c0 + 4});
    @(negedge sysClk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge sysClk);
      n_tests++;
      if (pSel !== 2'b10 || pAddr !== 8'h04 || pMask !== 4'b0011 || pWe !== 1'b1 ||
          pWdata !== 32'hCAFE_F00D || mEn !== 1'b0) begin
        n_fail++;
        $display("FAIL periph_hold k=%0d pSel=%b pAddr=%h pMask=%b pWe=%b pWdata=%h mEn=%b required 10 04 0011 1 cafef00d 0",
                 k, pSel, pAddr, pMask, pWe, pWdata, mEn);
      end
    end
    @(posedge sysClk); #1;
    pReady = 2'b11;
    wait_drain(ok);
    dReq = 1'b0; dWe = 1'b0; pReady = 2'b00;
    @(negedge sysClk);
    n_tests++;
    if (!ok || pSel !== 2'b00) begin
      n_fail++; $display("FAIL periph_release ok=%b pSel=%b required 1 00", ok, pSel);
    end
    // Channel 0 read that is ready immediately.
    pReady = 2'b01;
    @(posedge sysClk); #1; c0 = cyc;
    dReq = 1'b1; dAddr = 32'hFFFF_0010;
    sb.push_back('{1'b1, 1'b0, 32'h3333_4444, c0 + 1});
    wait_drain(ok);
    dReq = 1'b0; pReady = 2'b00;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL periph_read_drain ack_missing required=1"); end
  endtask

  task automatic test_timeout();
    int c0; bit ok;
    @(posedge sysClk); #1; c0 = cyc;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'hFFFF_0000;
    sb.push_back('{1'b1, 1'b1, 32'h0, c0 + 1 + TO});
    @(negedge sysClk);
    @(negedge sysClk);
    n_tests++;
    if (pSel !== 2'b01 || pWe !== 1'b0) begin
      n_fail++; $display("FAIL timeout_sel pSel=%b pWe=%b required 01 0", pSel, pWe);
    end
    wait_drain(ok);
    dReq = 1'b0;
    @(negedge sysClk);
    n_tests++;
    if (!ok || pSel !== 2'b00) begin
      n_fail++; $display("FAIL timeout_release ok=%b pSel=%b required 1 00", ok, pSel);
    end
    // Ready on the very cycle the counter reaches TIMEOUT wins.
    @(posedge sysClk); #1; c0 = cyc;
    dReq = 1'b1;
    sb.push_back('{1'b1, 1'b0, 32'h3333_4444, c0 + 1 + TO});
    repeat (1 + TO) @(posedge sysClk);
    #1 pReady = 2'b01;
    wait_drain(ok);
    dReq = 1'b0; pReady = 2'b00;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL timeout_edge_drain ack_missing required=1"); end
  endtask

  task automatic test_decode_err();
    int c0; bit ok;
    @(posedge sysClk); #1; c0 = cyc;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'hFFFF_0200;
    sb.push_back('{1'b1, 1'b1, 32'h0, c0 + 1});
    @(negedge sysClk);
    @(negedge sysClk);
    n_tests++;
    if (mEn !== 1'b0 || pSel !== 2'b00) begin
      n_fail++; $display("FAIL decode_err_strobe mEn=%b pSel=%b required 0 00", mEn, pSel);
    end
    wait_drain(ok);
    dReq = 1'b0;
    @(posedge sysClk); #1; c0 = cyc;
    iReq = 1'b1; iAddr = 32'hFFFF_0000;
    sb.push_back('{1'b0, 1'b1, 32'h0, c0 + 1});
    @(negedge sysClk);
    @(negedge sysClk);
    n_tests++;
    if (mEn !== 1'b0 || pSel !== 2'b00) begin
      n_fail++; $display("FAIL fetch_err_strobe mEn=%b pSel=%b required 0 00", mEn, pSel);
    end
    wait_drain(ok);
    iReq = 1'b0;
`ifdef BUS_STATS_EN
    @(negedge sysClk);
    n_tests++;
    if (errCnt !== 16'd3) begin n_fail++; $display("FAIL err_cnt got=%0d required=3", errCnt); end
`endif
  endtask

  task automatic test_reset_mid();
    int c0; bit ok;
    @(posedge sysClk); #1;
    iReq = 1'b1; iAddr = 32'h10;
    @(negedge sysClk);
    @(negedge sysClk);
    n_tests++;
    if (mEn !== 1'b1) begin n_fail++; $display("FAIL reset_mid_issue mEn=%b required 1", mEn); end
    sysRes = 1'b0;
    #1;
    n_tests++;
    if ({mEn, mWe, iAck, dAck, iErr, pSel} !== '0 || mAddr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_clear mEn=%b iAck=%b mAddr=%h required 0 0 0", mEn, iAck, mAddr);
    end
    iReq = 1'b0;
    repeat (2) @(posedge sysClk);
    #1 sysRes = 1'b1;
    @(posedge sysClk); #1; c0 = cyc;
    iReq = 1'b1; iAddr = 32'h10;
    sb.push_back('{1'b0, 1'b0, 32'hDEADBEEF, c0 + 2});
    wait_drain(ok);
    iReq = 1'b0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL reset_mid_after ack_missing required=1"); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_fetch();
    test_conflict();
    test_ram_write();
    test_periph();
    test_timeout();
    test_decode_err();
    test_reset_mid();
    repeat (3) @(posedge sysClk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time_limit_reached required=finish");
    $fatal(1, "watchdog");
  end

endmodule
